// File: rtl/wave_burst_controller.sv
// ----------------------------------------------------------------------------
// wave_burst_controller
//   Sequencer for one up/down triangle counter. On start it clears the
//   counter for one cycle, then paces it with a prescaled enable strobe,
//   tracks the count direction and counts completed triangle periods. A burst
//   ends at a trough (counter value 0), either after the requested number of
//   periods or, in any mode, after a stop request.
//
//   Optional build macro: WAVE_BURST_PAUSE_EN adds a 'pause' input. While it
//   is high in RUN, the strobe is suppressed and the pacing/tracking state
//   holds.
//
// Ports
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin a burst (accepted only in IDLE)
//   stop          : early stop, honoured at the next period boundary
//   pause         : (WAVE_BURST_PAUSE_EN only) freeze pacing while in RUN
//   div           : strobe spacing, one tri_ena every div+1 clocks
//   periods       : burst length in full periods, 0 = continuous
//   tri_value     : current triangle counter value
//   tri_clr       : registered synchronous clear to the counter
//   tri_ena       : count enable to the counter (decoded from state/prescaler)
//   busy          : high in CLEAR and RUN
//   done          : one-cycle pulse on burst completion
//   period_count  : periods completed in the current or last burst
// ----------------------------------------------------------------------------
module wave_burst_controller #(
   parameter int unsigned N     = 8,
   parameter int unsigned DIV_W = 16,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
`ifdef WAVE_BURST_PAUSE_EN
   input  logic             pause,
`endif
   input  logic [DIV_W-1:0] div,
   input  logic [CNT_W-1:0] periods,
   input  logic [N-1:0]     tri_value,
   output logic             tri_clr,
   output logic             tri_ena,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] period_count
);

   // Turn-around values of the counter: MAX-1 going up, 1 going down.
   localparam logic [N-1:0] PEAK_M1 = {{(N-1){1'b1}}, 1'b0};
   localparam logic [N-1:0] ONE     = N'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [DIV_W-1:0] div_q;
   logic [CNT_W-1:0] periods_q;
   logic [DIV_W-1:0] presc;
   logic             dir_down;
   logic             stop_pending;

   logic             paused;
   logic             strobe;
   logic             boundary;
   logic             finish;
   logic [CNT_W-1:0] pc_next;

`ifdef WAVE_BURST_PAUSE_EN
   assign paused = pause;
`else
   assign paused = 1'b0;
`endif

   // Strobe and period-boundary decode.
   assign strobe   = (state == RUN) && (presc == div_q) && !paused;
   assign tri_ena  = strobe;
   assign boundary = strobe && dir_down && (tri_value == ONE);
   assign pc_next  = period_count + CNT_W'(1);
   // A stop arriving on the boundary cycle itself also ends the burst.
   assign finish   = boundary &&
                     (((periods_q != '0) && (pc_next == periods_q)) ||
                      stop_pending || stop);

   // Burst sequencer with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         div_q        <= '0;
         periods_q    <= '0;
         presc        <= '0;
         dir_down     <= 1'b0;
         stop_pending <= 1'b0;
         tri_clr      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         period_count <= '0;
      end else begin
         tri_clr <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  div_q        <= div;
                  periods_q    <= periods;
                  period_count <= '0;
                  presc        <= '0;
                  stop_pending <= 1'b0;
                  dir_down     <= 1'b0;
                  tri_clr      <= 1'b1;
                  busy         <= 1'b1;
                  state        <= CLEAR;
               end
            end
            CLEAR: begin
               if (stop) stop_pending <= 1'b1;
               state <= RUN;
            end
            RUN: begin
               if (stop) stop_pending <= 1'b1;
               if (!paused) begin
                  presc <= strobe ? '0 : presc + DIV_W'(1);
               end
               if (strobe) begin
                  if (!dir_down && (tri_value == PEAK_M1)) begin
                     dir_down <= 1'b1;
                  end else if (boundary) begin
                     dir_down     <= 1'b0;
                     period_count <= pc_next;
                  end
               end
               if (finish) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
